// File: rtl/lux_lcd_writer.sv
// lux_lcd_writer: converts each lux sample to ASCII digits and streams an LCD cursor command plus five characters.
module lux_lcd_writer #(
   parameter int P_ROW       = 0,
   parameter int P_COL       = 11,
   parameter int P_CONV_WAIT = 2,
   parameter int P_BLANK     = 1
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_sample_valid,
   input  logic [15:0] i_sample,
   output logic        o_conv_start,
   output logic [15:0] o_conv_data,
   input  logic [7:0]  i_byte0,
   input  logic [7:0]  i_byte1,
   input  logic [7:0]  i_byte2,
   input  logic [7:0]  i_byte3,
   input  logic [7:0]  i_byte4,
   output logic        o_lcd_valid,
   output logic        o_lcd_rs,
   output logic [7:0]  o_lcd_data,
   input  logic        i_lcd_ready,
   output logic        o_busy,
   output logic        o_dropped
);
   typedef enum logic [2:0] {S_IDLE, S_CONV, S_CAPTURE, S_ADDR, S_DIGIT} state_t;
   localparam int         L_CW   = $clog2(P_CONV_WAIT + 1);
   localparam logic [7:0] L_ADDR = 8'h80 | ((P_ROW != 0) ? 8'h40 : 8'h00) | 8'(P_COL);
   state_t          r_state;
   logic [L_CW-1:0] r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_buf [5];
   logic            r_pend_vld;
   logic [15:0]     r_pend;
   logic            w_busy, w_bl4, w_bl3, w_bl2, w_bl1;
   assign w_busy = r_state != S_IDLE;
   assign o_busy = w_busy;
   assign w_bl4  = (P_BLANK != 0) && (i_byte4 == 8'h30);
   assign w_bl3  = w_bl4 && (i_byte3 == 8'h30);
   assign w_bl2  = w_bl3 && (i_byte2 == 8'h30);
   assign w_bl1  = w_bl2 && (i_byte1 == 8'h30);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pend_vld   <= 1'b0;
         r_pend       <= '0;
         o_conv_start <= 1'b0;
         o_conv_data  <= '0;
         o_lcd_valid  <= 1'b0;
         o_lcd_rs     <= 1'b0;
         o_lcd_data   <= '0;
         o_dropped    <= 1'b0;
         for (int k = 0; k < 5; k++) r_buf[k] <= 8'h20;
      end else begin
         o_conv_start <= 1'b0;
         o_dropped    <= 1'b0;
         if (i_sample_valid && (w_busy || r_pend_vld)) begin
            r_pend     <= i_sample;
            r_pend_vld <= 1'b1;
            o_dropped  <= w_busy && r_pend_vld;
         end
         case (r_state)
            S_IDLE: if (r_pend_vld || i_sample_valid) begin
               o_conv_data  <= r_pend_vld ? r_pend : i_sample;
               r_pend_vld   <= r_pend_vld && i_sample_valid;
               o_conv_start <= 1'b1;
               r_cnt        <= L_CW'(P_CONV_WAIT - 1);
               r_state      <= S_CONV;
            end
            S_CONV: if (r_cnt == '0) r_state <= S_CAPTURE;
                    else r_cnt <= r_cnt - 1'b1;
            S_CAPTURE: begin
               r_buf[4]    <= w_bl4 ? 8'h20 : i_byte4;
               r_buf[3]    <= w_bl3 ? 8'h20 : i_byte3;
               r_buf[2]    <= w_bl2 ? 8'h20 : i_byte2;
               r_buf[1]    <= w_bl1 ? 8'h20 : i_byte1;
               r_buf[0]    <= i_byte0;
               o_lcd_valid <= 1'b1;
               o_lcd_rs    <= 1'b0;
               o_lcd_data  <= L_ADDR;
               r_state     <= S_ADDR;
            end
            S_ADDR: if (i_lcd_ready) begin
               o_lcd_rs   <= 1'b1;
               o_lcd_data <= r_buf[4];
               r_idx      <= 3'd4;
               r_state    <= S_DIGIT;
            end
            S_DIGIT: if (i_lcd_ready) begin
               if (r_idx == 3'd0) begin
                  o_lcd_valid <= 1'b0;
                  o_lcd_rs    <= 1'b0;
                  o_lcd_data  <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  o_lcd_data <= r_buf[r_idx - 3'd1];
                  r_idx      <= r_idx - 3'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lux_lcd_writer.sv
// tb_lux_lcd_writer: directed bench with a decimal converter model and byte/handshake monitors.
module tb_lux_lcd_writer;
   logic        clk = 1'b0, rst_n, sv, rdy;
   logic [15:0] smp;
   logic        cs0, cs1, cs2, v0, v1, v2, rs0, rs1, rs2, b0, b1, b2, dr0, dr1, dr2;
   logic [15:0] cd0, cd1, cd2;
   logic [7:0]  d0, d1, d2;
   logic [39:0] m0, m1, m2;
   logic [8:0]  q0[$], q1[$], q2[$];
   logic [15:0] cq[$];
   logic        hold0 = 1'b0;
   logic [9:0]  h0;
   int          n_chk = 0, n_fail = 0, n_drop = 0;

   always #5 clk = ~clk;

   lux_lcd_writer u0 (.i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sv), .i_sample(smp),
      .o_conv_start(cs0), .o_conv_data(cd0), .i_byte0(m0[7:0]), .i_byte1(m0[15:8]),
      .i_byte2(m0[23:16]), .i_byte3(m0[31:24]), .i_byte4(m0[39:32]), .o_lcd_valid(v0),
      .o_lcd_rs(rs0), .o_lcd_data(d0), .i_lcd_ready(rdy), .o_busy(b0), .o_dropped(dr0));
   lux_lcd_writer #(.P_ROW(1), .P_COL(0)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sv),
      .i_sample(smp), .o_conv_start(cs1), .o_conv_data(cd1), .i_byte0(m1[7:0]), .i_byte1(m1[15:8]),
      .i_byte2(m1[23:16]), .i_byte3(m1[31:24]), .i_byte4(m1[39:32]), .o_lcd_valid(v1),
      .o_lcd_rs(rs1), .o_lcd_data(d1), .i_lcd_ready(rdy), .o_busy(b1), .o_dropped(dr1));
   lux_lcd_writer #(.P_ROW(1), .P_COL(0), .P_BLANK(0)) u2 (.i_clk(clk), .i_rst_n(rst_n),
      .i_sample_valid(sv), .i_sample(smp), .o_conv_start(cs2), .o_conv_data(cd2),
      .i_byte0(m2[7:0]), .i_byte1(m2[15:8]), .i_byte2(m2[23:16]), .i_byte3(m2[31:24]),
      .i_byte4(m2[39:32]), .o_lcd_valid(v2), .o_lcd_rs(rs2), .o_lcd_data(d2),
      .i_lcd_ready(rdy), .o_busy(b2), .o_dropped(dr2));

   function automatic logic [39:0] digits(input logic [15:0] v);
      int t = int'(v);
      logic [39:0] r;
      for (int k = 0; k < 5; k++) begin
         r[8*k +: 8] = 8'(48 + t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (cs0) m0 <= digits(cd0);
      if (cs1) m1 <= digits(cd1);
      if (cs2) m2 <= digits(cd2);
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (v0 && rdy) q0.push_back({rs0, d0});
         if (v1 && rdy) q1.push_back({rs1, d1});
         if (v2 && rdy) q2.push_back({rs2, d2});
         if (cs0) cq.push_back(cd0);
         if (dr0) n_drop++;
         if (hold0) begin
            n_chk++;
            if ({v0, rs0, d0} !== h0) begin
               n_fail++;
               $display("FAIL hold_stable: got %h expected %h", {v0, rs0, d0}, h0);
            end
         end
         hold0 = v0 && !rdy;
         h0    = {v0, rs0, d0};
      end else hold0 = 1'b0;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [15:0] v);
      sv  = 1'b1;
      smp = v;
      tick();
      sv  = 1'b0;
   endtask

   task automatic clear_logs;
      q0.delete(); q1.delete(); q2.delete(); cq.delete();
      n_drop = 0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rdy = 1'b1; sv = 1'b0; smp = '0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({v0, rs0, d0, cs0, cd0, b0, dr0} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", {v0, rs0, d0, cs0, cd0, b0, dr0});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++;
         if ({v0, rs0, d0, cs0, cd0, b0, dr0} !== 29'd0) begin
            n_fail++;
            $display("FAIL idle_outputs cycle %0d: got %h expected 0", i, {v0, rs0, d0, cs0, cd0, b0, dr0});
         end
      end
   endtask

   task automatic test_basic;
      logic [8:0] e[6] = '{9'h08B, 9'h120, 9'h131, 9'h133, 9'h133, 9'h137};
      pulse(16'h0539);
      n_chk++;
      if ({cs0, b0} !== 2'b11) begin
         n_fail++;
         $display("FAIL basic_start: got start/busy %b expected 11", {cs0, b0});
      end
      tick();
      n_chk++;
      if ({cs0, cd0} !== {1'b0, 16'h0539}) begin
         n_fail++;
         $display("FAIL basic_start_pulse: got %h expected 00539", {cs0, cd0});
      end
      tick();
      n_chk++;
      if (v0 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_capture_valid: got %b expected 0", v0);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_chk++;
         if ({v0, rs0, d0} !== {1'b1, e[i]}) begin
            n_fail++;
            $display("FAIL basic_byte%0d: got %h expected %h", i, {v0, rs0, d0}, {1'b1, e[i]});
         end
      end
      tick();
      n_chk++;
      if ({b0, v0} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_done: got busy/valid %b expected 00", {b0, v0});
      end
   endtask

   task automatic test_back_to_back;
      clear_logs();
      pulse(16'd7);
      repeat (8) tick();
      pulse(16'd42);
      n_chk++;
      if ({b0, cs0} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_idle: got busy/start %b expected 00", {b0, cs0});
      end
      tick();
      n_chk++;
      if ({cs0, cd0} !== {1'b1, 16'd42}) begin
         n_fail++;
         $display("FAIL b2b_restart: got %h expected %h", {cs0, cd0}, {1'b1, 16'd42});
      end
      repeat (12) tick();
      n_chk++;
      if (n_drop !== 0 || q0.size() !== 12) begin
         n_fail++;
         $display("FAIL b2b_counts: got drops %0d bytes %0d expected 0 12", n_drop, q0.size());
      end
   endtask

   task automatic test_ready_toggle;
      logic [8:0] e[6] = '{9'h08B, 9'h136, 9'h135, 9'h135, 9'h133, 9'h135};
      clear_logs();
      pulse(16'hFFFF);
      for (int i = 0; i < 100 && b0; i++) begin
         rdy = ~rdy;
         tick();
      end
      n_chk++;
      if (b0 !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_timeout: got busy %b expected 0", b0);
      end
      rdy = 1'b1;
      n_chk++;
      if (q0.size() !== 6) begin
         n_fail++;
         $display("FAIL toggle_count: got %0d expected 6", q0.size());
      end else for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (q0[i] !== e[i]) begin
            n_fail++;
            $display("FAIL toggle_byte%0d: got %h expected %h", i, q0[i], e[i]);
         end
      end
   endtask

   task automatic test_pending;
      logic [8:0] e[12] = '{9'h08B, 9'h120, 9'h120, 9'h120, 9'h131, 9'h130,
                            9'h08B, 9'h120, 9'h120, 9'h120, 9'h133, 9'h130};
      clear_logs();
      pulse(16'd10);
      tick();
      pulse(16'd20);
      pulse(16'd30);
      n_chk++;
      if ({dr0, cd0} !== {1'b1, 16'd10}) begin
         n_fail++;
         $display("FAIL pend_drop: got %h expected %h", {dr0, cd0}, {1'b1, 16'd10});
      end
      repeat (25) tick();
      n_chk++;
      if (n_drop !== 1 || cq.size() !== 2) begin
         n_fail++;
         $display("FAIL pend_counts: got drops %0d convs %0d expected 1 2", n_drop, cq.size());
      end else begin
         n_chk++;
         if (cq[0] !== 16'd10 || cq[1] !== 16'd30) begin
            n_fail++;
            $display("FAIL pend_values: got %0d %0d expected 10 30", cq[0], cq[1]);
         end
      end
      n_chk++;
      if (q0.size() !== 12) begin
         n_fail++;
         $display("FAIL pend_bytes: got %0d expected 12", q0.size());
      end else for (int i = 0; i < 12; i++) begin
         n_chk++;
         if (q0[i] !== e[i]) begin
            n_fail++;
            $display("FAIL pend_byte%0d: got %h expected %h", i, q0[i], e[i]);
         end
      end
   endtask

   task automatic test_zero;
      logic [8:0] e0[6] = '{9'h08B, 9'h120, 9'h120, 9'h120, 9'h120, 9'h130};
      logic [8:0] e1[6] = '{9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120, 9'h130};
      logic [8:0] e2[6] = '{9'h0C0, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130};
      clear_logs();
      pulse(16'd0);
      repeat (12) tick();
      n_chk++;
      if (q0.size() !== 6 || q1.size() !== 6 || q2.size() !== 6) begin
         n_fail++;
         $display("FAIL zero_counts: got %0d %0d %0d expected 6 6 6", q0.size(), q1.size(), q2.size());
      end else for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (q0[i] !== e0[i] || q1[i] !== e1[i] || q2[i] !== e2[i]) begin
            n_fail++;
            $display("FAIL zero_byte%0d: got %h %h %h expected %h %h %h",
                     i, q0[i], q1[i], q2[i], e0[i], e1[i], e2[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [8:0] e[6] = '{9'h08B, 9'h120, 9'h120, 9'h132, 9'h135, 9'h130};
      pulse(16'h0539);
      tick();
      tick();
      pulse(16'd9);
      repeat (3) tick();
      n_chk++;
      if ({v0, rs0, d0} !== 10'h333) begin
         n_fail++;
         $display("FAIL mid_digit2: got %h expected 333", {v0, rs0, d0});
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({v0, b0} !== 2'b00) begin
         n_fail++;
         $display("FAIL mid_async: got valid/busy %b expected 00", {v0, b0});
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         n_chk++;
         if ({b0, cs0, v0} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_idle cycle %0d: got %b expected 000", i, {b0, cs0, v0});
         end
      end
      clear_logs();
      pulse(16'd250);
      repeat (12) tick();
      n_chk++;
      if (q0.size() !== 6) begin
         n_fail++;
         $display("FAIL mid_count: got %0d expected 6", q0.size());
      end else for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (q0[i] !== e[i]) begin
            n_fail++;
            $display("FAIL mid_byte%0d: got %h expected %h", i, q0[i], e[i]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ready_toggle();
      test_pending();
      test_zero();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
